// File: rtl/branch_predict_ctrl.sv
// Purpose: E-stage branch resolution, bimodal 2-bit predictor table, mispredict redirect/flush and statistics.
// Latency: prediction and resolution outputs are combinational (0 cycles); table and counter updates land on the next rising edge.
// Backpressure: none; StallE or a bubble in E (ValidE=0) suppresses resolution, table update, counting and redirect.
module branch_predict_ctrl #(
    parameter  int XLEN        = 32,
    parameter  int BHT_ENTRIES = 16,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic [2:0]       funct3E,
    input  logic             ZeroE,
    input  logic             LtE,
    input  logic             LtuE,
    input  logic [XLEN-1:0]  PCE,
    input  logic             PredTakenE,
    output logic             TakenE,
    output logic             RedirectE,
    output logic             RedirectSelE,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    // 2-bit counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic             br_cond;
    logic             active;
    logic             mispredict;
    logic             branch_upd;
    logic             unused_pc_bits;

    // Word-aligned PCs: byte-offset bits and bits above the index do not select an entry
    assign idx_f = PCF[IDX_W+1:2];
    assign idx_e = PCE[IDX_W+1:2];
    assign unused_pc_bits = ^{PCF[XLEN-1:IDX_W+2], PCF[1:0], PCE[XLEN-1:IDX_W+2], PCE[1:0]};

    // Prediction is the direction bit of the registered counter; same-cycle updates are not forwarded
    assign PredTakenF = bht[idx_f][1];

    // Decode the conditional branch outcome from funct3 and the ALU compare flags
    always_comb begin
        br_cond = 1'b0;
        case (funct3E)
            3'b000:  br_cond = ZeroE;
            3'b001:  br_cond = ~ZeroE;
            3'b100:  br_cond = LtE;
            3'b101:  br_cond = ~LtE;
            3'b110:  br_cond = LtuE;
            3'b111:  br_cond = ~LtuE;
            default: br_cond = 1'b0;
        endcase
    end

    // Resolved outcome: jumps are always taken and take priority over the branch decode
    always_comb begin
        TakenE = 1'b0;
        if (JumpE) begin
            TakenE = 1'b1;
        end else if (BranchE) begin
            TakenE = br_cond;
        end
    end

    assign active       = ValidE & ~StallE & (BranchE | JumpE);
    assign mispredict   = active & (TakenE != PredTakenE);
    assign branch_upd   = active & BranchE & ~JumpE;

    // Taken mispredict goes to the target, not-taken mispredict falls back to PC+4
    assign RedirectE    = mispredict;
    assign RedirectSelE = mispredict & ~TakenE;
    assign FlushD       = mispredict;
    assign FlushE       = mispredict;

    // Counter table: reset to weak-NT, saturating train on resolved conditional branches only
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (branch_upd) begin
            if (TakenE) begin
                if (bht[idx_e] != 2'b11) begin
                    bht[idx_e] <= bht[idx_e] + 2'd1;
                end
            end else begin
                if (bht[idx_e] != 2'b00) begin
                    bht[idx_e] <= bht[idx_e] - 2'd1;
                end
            end
        end
    end

    // Saturating statistics: conditional branches resolved and total mispredicts (jumps included)
    always_ff @(posedge clk) begin
        if (reset) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else begin
            if (branch_upd && (BranchCnt != '1)) begin
                BranchCnt <= BranchCnt + CNT_W'(1);
            end
            if (mispredict && (MispredCnt != '1)) begin
                MispredCnt <= MispredCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed vectors, expectations queued at issue.
// A negedge monitor pops one expectation per issued cycle and compares every output.
// Prints one summary line with check and error counts.
`timescale 1ns/1ps
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic        ValidE, StallE, BranchE, JumpE;
    logic [2:0]  funct3E;
    logic        ZeroE, LtE, LtuE;
    logic [31:0] PCE;
    logic        PredTakenE;
    logic        TakenE, RedirectE, RedirectSelE, FlushD, FlushE;
    logic [15:0] BranchCnt, MispredCnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic        pf, tk, rd, rs, fd, fe;
        logic [15:0] bc, mc;
    } exp_t;

    exp_t exp_q[$];

    branch_predict_ctrl dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
        .ValidE(ValidE), .StallE(StallE), .BranchE(BranchE), .JumpE(JumpE),
        .funct3E(funct3E), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .PCE(PCE), .PredTakenE(PredTakenE), .TakenE(TakenE),
        .RedirectE(RedirectE), .RedirectSelE(RedirectSelE),
        .FlushD(FlushD), .FlushE(FlushE),
        .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input string fld, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %b want %b", nm, fld, act, req);
        end
    endtask

    task automatic chk16(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, req);
        end
    endtask

    // Monitor: compares the live outputs against the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk1 (e.nm, "PredTakenF",   PredTakenF,   e.pf);
            chk1 (e.nm, "TakenE",       TakenE,       e.tk);
            chk1 (e.nm, "RedirectE",    RedirectE,    e.rd);
            chk1 (e.nm, "RedirectSelE", RedirectSelE, e.rs);
            chk1 (e.nm, "FlushD",       FlushD,       e.fd);
            chk1 (e.nm, "FlushE",       FlushE,       e.fe);
            chk16(e.nm, "BranchCnt",    BranchCnt,    e.bc);
            chk16(e.nm, "MispredCnt",   MispredCnt,   e.mc);
        end
    end

    task automatic set_in(input logic [31:0] pcf, input logic v, input logic st, input logic br,
                          input logic jp, input logic [2:0] f3, input logic z, input logic lt,
                          input logic ltu, input logic [31:0] pce, input logic pt);
        PCF = pcf; ValidE = v; StallE = st; BranchE = br; JumpE = jp; funct3E = f3;
        ZeroE = z; LtE = lt; LtuE = ltu; PCE = pce; PredTakenE = pt;
    endtask

    // Issue one cycle of stimulus with its hand-computed expected outputs; counts are the pre-edge values
    task automatic drive(input string nm, input logic [31:0] pcf, input logic v, input logic st,
                         input logic br, input logic jp, input logic [2:0] f3, input logic z,
                         input logic lt, input logic ltu, input logic [31:0] pce, input logic pt,
                         input logic e_pf, input logic e_tk, input logic e_rd, input logic e_rs,
                         input logic e_fl, input logic [15:0] e_bc, input logic [15:0] e_mc);
        exp_t e;
        set_in(pcf, v, st, br, jp, f3, z, lt, ltu, pce, pt);
        e.nm = nm; e.pf = e_pf; e.tk = e_tk; e.rd = e_rd; e.rs = e_rs;
        e.fd = e_fl; e.fe = e_fl; e.bc = e_bc; e.mc = e_mc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(32'h0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        //    name           PCF        V  S  B  J  f3      Z  L  U  PCE        PT   pf tk rd rs fl BranchCnt MispredCnt
        drive("rst_pred",    32'h100,   0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   0, 0, 0, 0, 0, 16'd0, 16'd0);
        drive("beq_mis",     32'h100,   1, 0, 1, 0, 3'b000, 1, 0, 0, 32'h100,   0,   0, 1, 1, 0, 1, 16'd0, 16'd0);
        drive("beq_after",   32'h100,   0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   1, 0, 0, 0, 0, 16'd1, 16'd1);

        // 0x40 shares entry 0 with 0x100, so restart from a clean table for the counter walk
        do_reset();
        drive("rst2",        32'h40,    0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   0, 0, 0, 0, 0, 16'd0, 16'd0);
        drive("bne_t1",      32'h40,    1, 0, 1, 0, 3'b001, 0, 0, 0, 32'h40,    0,   0, 1, 1, 0, 1, 16'd0, 16'd0);
        drive("bne_t2",      32'h40,    1, 0, 1, 0, 3'b001, 0, 0, 0, 32'h40,    1,   1, 1, 0, 0, 0, 16'd1, 16'd1);
        drive("bne_t3",      32'h40,    1, 0, 1, 0, 3'b001, 0, 0, 0, 32'h40,    1,   1, 1, 0, 0, 0, 16'd2, 16'd1);
        drive("bne_nt",      32'h40,    1, 0, 1, 0, 3'b001, 1, 0, 0, 32'h40,    1,   1, 0, 1, 1, 1, 16'd3, 16'd1);
        drive("bne_after",   32'h40,    0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   1, 0, 0, 0, 0, 16'd4, 16'd2);
        drive("bne_nt2",     32'h40,    1, 0, 1, 0, 3'b001, 1, 0, 0, 32'h40,    1,   1, 0, 1, 1, 1, 16'd4, 16'd2);
        drive("bne_nt2_aft", 32'h40,    0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   0, 0, 0, 0, 0, 16'd5, 16'd3);

        drive("bgeu_stall",  32'h8,     1, 1, 1, 0, 3'b111, 0, 0, 1, 32'h8,     1,   0, 0, 0, 0, 0, 16'd5, 16'd3);
        drive("bgeu_bubble", 32'h8,     0, 0, 1, 0, 3'b111, 0, 0, 0, 32'h8,     0,   0, 1, 0, 0, 0, 16'd5, 16'd3);
        drive("bgeu",        32'h8,     1, 0, 1, 0, 3'b111, 0, 0, 1, 32'h8,     1,   0, 0, 1, 1, 1, 16'd5, 16'd3);
        drive("bgeu_after",  32'h8,     0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   0, 0, 0, 0, 0, 16'd6, 16'd4);
        drive("blt_t",       32'h8,     1, 0, 1, 0, 3'b100, 0, 1, 0, 32'h8,     0,   0, 1, 1, 0, 1, 16'd6, 16'd4);
        drive("bge_t",       32'h8,     1, 0, 1, 0, 3'b101, 0, 0, 0, 32'h8,     0,   0, 1, 1, 0, 1, 16'd7, 16'd5);
        drive("bge_after",   32'h8,     0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   1, 0, 0, 0, 0, 16'd8, 16'd6);
        drive("f3_010",      32'h8,     1, 0, 1, 0, 3'b010, 1, 1, 1, 32'h8,     0,   1, 0, 0, 0, 0, 16'd8, 16'd6);

        drive("jal",         32'h80,    1, 0, 0, 1, 3'b010, 0, 0, 0, 32'h80,    0,   0, 1, 1, 0, 1, 16'd9, 16'd6);
        drive("jal_br",      32'h80,    1, 0, 1, 1, 3'b000, 0, 0, 0, 32'h80,    0,   0, 1, 1, 0, 1, 16'd9, 16'd7);
        drive("jal_after",   32'h80,    0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   0, 0, 0, 0, 0, 16'd9, 16'd8);
        drive("jal_pred",    32'h80,    1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h80,    1,   0, 1, 0, 0, 0, 16'd9, 16'd8);

        drive("alias_upd",   32'h144,   1, 0, 1, 0, 3'b000, 1, 0, 0, 32'h104,   0,   0, 1, 1, 0, 1, 16'd9, 16'd8);
        drive("alias_after", 32'h144,   0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   1, 0, 0, 0, 0, 16'd10, 16'd9);

        // Bring MispredCnt from 9 to 0xFFFE with back-to-back mispredicted jumps
        for (int i = 0; i < 32'hFFFE - 9; i++) begin
            set_in(32'h80, 1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h80, 0);
            @(posedge clk);
            #1;
        end
        drive("sat_a",       32'h80,    1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h80,    0,   0, 1, 1, 0, 1, 16'd10, 16'hFFFE);
        drive("sat_b",       32'h80,    1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h80,    0,   0, 1, 1, 0, 1, 16'd10, 16'hFFFF);
        drive("sat_c",       32'h80,    1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h80,    0,   0, 1, 1, 0, 1, 16'd10, 16'hFFFF);
        drive("sat_hold",    32'h80,    0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0,     0,   0, 0, 0, 0, 0, 16'd10, 16'hFFFF);

        // Reset arrives with a valid taken branch in E; comb outputs still follow inputs
        reset = 1'b1;
        drive("rst_branch",  32'h144,   1, 0, 1, 0, 3'b000, 1, 0, 0, 32'h104,   0,   1, 1, 1, 0, 1, 16'd10, 16'hFFFF);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive("sweep", 32'(i * 4), 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Execute-stage branch resolution and prediction controller for the 5-stage RV32I pipeline.
- Holds a bimodal table of 2-bit saturating counters read by fetch with PCF.
- Resolves conditional branches in E from funct3E and ALU flags, and detects mispredictions.
- On a misprediction, drives the fetch redirect and the D/E flushes; also keeps branch and mispredict statistics.

Parameters:
- XLEN, 32, address width of PCF/PCE.
- BHT_ENTRIES, 16, number of counters; power of two, ≥2.
- IDX_W, $clog2(BHT_ENTRIES), table index width; derived, not overridden.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- PCF  in  XLEN  fetch PC.
- PredTakenF  out  1  prediction for the instruction at PCF.
- ValidE  in  1  E stage holds a real instruction (not a bubble).
- StallE  in  1  E stage held this cycle.
- BranchE  in  1  E instruction is a conditional branch.
- JumpE  in  1  E instruction is JAL/JALR.
- funct3E  in  3  branch condition.
- ZeroE  in  1  ALU result == 0.
- LtE  in  1  signed rs1 < rs2.
- LtuE  in  1  unsigned rs1 < rs2.
- PCE  in  XLEN  PC of E instruction.
- PredTakenE  in  1  PredTakenF value piped down to E.
- TakenE  out  1  resolved outcome.
- RedirectE  out  1  fetch must be redirected this cycle.
- RedirectSelE  out  1  0 = PCTargetE, 1 = PCPlus4E.
- FlushD  out  1  flush D stage.
- FlushE  out  1  flush E stage.
- BranchCnt  out  CNT_W  resolved conditional branches.
- MispredCnt  out  CNT_W  mispredicted branches and jumps.

Behaviour:
- Table index = PC[IDX_W+1:2] (word aligned).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- PredTakenF = bit 1 of table[index(PCF)]. Combinational read of registered state; 0-cycle latency.

Condition decode (comb), when BranchE:
- 000 BEQ → ZeroE; 001 BNE → !ZeroE.
- 100 BLT → LtE; 101 BGE → !LtE.
- 110 BLTU → LtuE; 111 BGEU → !LtuE.
- 010/011 → not taken.
- JumpE → TakenE=1, regardless of funct3E. BranchE and JumpE both high: JumpE wins.
- Neither BranchE nor JumpE → TakenE=0.

Active = ValidE & !StallE & (BranchE | JumpE).
- Mispredict = Active & (TakenE != PredTakenE).
- RedirectE = Mispredict.
- RedirectSelE = !TakenE. Value is don't-care when RedirectE=0; drive 0 then.
- FlushD = FlushE = RedirectE, same cycle (comb). The hazard unit ORs these with its own flushes.

Table update, at clock edge when Active & BranchE & !JumpE:
- Taken increments the entry at index(PCE), saturating at 11.
- Not taken decrements it, saturating at 00.
- Jumps never update the table.
- Read/write same index in the same cycle: PredTakenF shows the pre-update value; the new value is visible the next cycle.

Statistics:
- BranchCnt += 1 on each Active conditional branch.
- MispredCnt += 1 on each Mispredict, including jumps.
- Both saturate at all-ones, no wrap.
- StallE high or ValidE low: no update, no count, no redirect. A stalled branch resolves exactly once, in its unstalled cycle.

Reset (synchronous):
- All table entries ← 01 in one cycle.
- BranchCnt = MispredCnt = 0.
- PredTakenF = 0 the cycle after reset.
- Comb outputs (TakenE, RedirectE, RedirectSelE, FlushD, FlushE) are not gated by reset; they follow their inputs, so the bench must hold ValidE=0 during reset.
- Reset asserted while a branch is in E: the table/counter update for that cycle is suppressed; reset wins.

Test Plan:
- Reset, then PCF=0x100 → PredTakenF=0. Branch BEQ at PCE=0x100, ZeroE=1, PredTakenE=0, ValidE=1 → TakenE=1, RedirectE=1, RedirectSelE=0, FlushD=FlushE=1, MispredCnt=1; next cycle PredTakenF(0x100)=1 (entry 10).
- Three taken BNE at PCE=0x40 (ZeroE=0), then one not taken → entry walks 01→10→11→11→10; PredTakenF stays 1 after the not-taken; BranchCnt=4.
- BGEU with LtuE=1, PredTakenE=1 → TakenE=0, RedirectE=1, RedirectSelE=1. Same with StallE=1 → no redirect, no count, no table change.
- JumpE=1, PredTakenE=0 at PCE=0x80 → RedirectE=1, RedirectSelE=0; table entry for 0x80 unchanged; BranchCnt unchanged; MispredCnt+1.
- Aliasing and same-cycle access: PCE=0x104 and PCF=0x144 (same index for 16 entries) on an update cycle → PredTakenF shows the old bit; the new bit appears the next cycle.
- Force MispredCnt to 0xFFFE, inject 3 mispredicts → 0xFFFF, held. Assert reset with a valid branch in E → no update; all entries read 01 afterwards.
